// File: rtl/ctrl_pkg.sv
// Shared encodings and control bundles for the ARM-subset instruction decoder.
// Imported by the top-level decoder and its ALU decode sub-block.
package ctrl_pkg;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Instruction class, instruction bits [27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Immediate extension format
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Data-processing cmd field, Funct[4:1]
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] REG_PC = 4'b1111;

  // Main-decode result before ALU decode and PC-write resolution.
  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  // Registered output bundle driven onto the datapath.
  typedef struct packed {
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_control;
  } out_t;

  // Carry/overflow are only meaningful for the arithmetic operations.
  function automatic logic writes_cv(input logic [1:0] alu_control);
    return (alu_control == ALU_ADD) || (alu_control == ALU_SUB);
  endfunction

endpackage

// File: rtl/instr_decoder_alu.sv
// ALU decode: maps the data-processing cmd/S bits to an ALU operation and
// flag-write enables, and flags cmd values outside the supported subset.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    illegal     = 1'b0;
    if (alu_op) begin
      unique case (funct[4:1])
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        default: illegal     = 1'b1;
      endcase
      // Unsupported cmd must not touch the flags either.
      if (!illegal) begin
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & writes_cv(alu_control);
      end
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Registered control decoder: main decode, ALU decode, PC-write detection,
// then a single output register with asynchronous active-low reset.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  ctrl_t      ctrl;
  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic       illegal;
  logic       reg_w_final;
  out_t       out_d;
  out_t       out_q;

  always_comb begin
    ctrl = '0;
    unique case (Op)
      OP_DP: begin
        ctrl.imm_src = IMM_DP;
        ctrl.alu_src = Funct[5];
        ctrl.reg_w   = 1'b1;
        ctrl.alu_op  = 1'b1;
      end
      OP_MEM: begin
        ctrl.imm_src    = IMM_MEM;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        if (Funct[0]) begin
          ctrl.reg_w = 1'b1;
        end else begin
          // Stores read Rd as the data source through the second port.
          ctrl.reg_src = 2'b10;
          ctrl.mem_w   = 1'b1;
        end
      end
      OP_BR: begin
        ctrl.reg_src = 2'b01;
        ctrl.imm_src = IMM_BR;
        ctrl.alu_src = 1'b1;
        ctrl.branch  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct       (Funct[4:0]),
    .alu_op      (ctrl.alu_op),
    .alu_control (alu_control),
    .flag_w      (flag_w),
    .illegal     (illegal)
  );

  assign reg_w_final = ctrl.reg_w & ~illegal;

  always_comb begin
    out_d             = '0;
    out_d.flag_w      = flag_w;
    out_d.pcs         = ((Rd == REG_PC) & reg_w_final) | ctrl.branch;
    out_d.reg_w       = reg_w_final;
    out_d.mem_w       = ctrl.mem_w;
    out_d.mem_to_reg  = ctrl.mem_to_reg;
    out_d.alu_src     = ctrl.alu_src;
    out_d.imm_src     = ctrl.imm_src;
    out_d.reg_src     = ctrl.reg_src;
    out_d.alu_control = alu_control;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign FlagW      = out_q.flag_w;
  assign PCS        = out_q.pcs;
  assign RegW       = out_q.reg_w;
  assign MemW       = out_q.mem_w;
  assign MemtoReg   = out_q.mem_to_reg;
  assign ALUSrc     = out_q.alu_src;
  assign ImmSrc     = out_q.imm_src;
  assign RegSrc     = out_q.reg_src;
  assign ALUControl = out_q.alu_control;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: reset/latency sequences, a directed vector table,
// and randomized instructions checked against a rule-level reference model.
module tb_instr_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       MemtoReg;
  logic       ALUSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  int vectors;
  int miscompares;

  // Packed as {FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl}
  typedef struct {
    string      name;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [12:0] exp_q[$];

  instr_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic [1:0] flagw, input logic pcs,
                                     input logic regw, input logic memw,
                                     input logic mtr, input logic alusrc,
                                     input logic [1:0] imm, input logic [1:0] regsrc,
                                     input logic [1:0] aluc);
    return {flagw, pcs, regw, memw, mtr, alusrc, imm, regsrc, aluc};
  endfunction

  // Reference model: classify the instruction, then assemble its controls.
  function automatic logic [12:0] ref_model(input logic [1:0] op, input logic [5:0] funct,
                                            input logic [3:0] rd);
    logic [3:0] legal_cmd [4];
    int         idx;
    logic       to_pc;
    legal_cmd[0] = 4'b0100;  // ADD -> ALUControl 0
    legal_cmd[1] = 4'b0010;  // SUB -> 1
    legal_cmd[2] = 4'b0000;  // AND -> 2
    legal_cmd[3] = 4'b1100;  // ORR -> 3
    to_pc = (rd == 4'd15);
    if (op == 2'd3) return '0;
    if (op == 2'd2) return pk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00);
    if (op == 2'd1) begin
      if (funct[0]) return pk(2'b00, to_pc, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00);
      return pk(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b00);
    end
    idx = -1;
    for (int k = 0; k < 4; k++) if (funct[4:1] == legal_cmd[k]) idx = k;
    if (idx < 0) return pk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, funct[5], 2'b00, 2'b00, 2'b00);
    return pk(funct[0] ? ((idx < 2) ? 2'b11 : 2'b10) : 2'b00, to_pc, 1'b1, 1'b0, 1'b0,
              funct[5], 2'b00, 2'b00, 2'(idx));
  endfunction

  function automatic logic [12:0] dut_outs();
    return {FlagW, PCS, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl};
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = dut_outs();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %013b expected %013b (FlagW PCS RegW MemW MtR ALUSrc ImmSrc RegSrc ALUC)",
               name, act, exp);
    end
  endtask

  // Driver: change inputs away from the active edge, sample just after it.
  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
    @(negedge clk);
    Op    = op;
    Funct = funct;
    Rd    = rd;
  endtask

  task automatic apply(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [12:0] exp);
    drive(op, funct, rd);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset asserted from time zero with arbitrary inputs, before any edge.
    reset = 1'b0;
    Op    = 2'b00;
    Funct = 6'b101001;
    Rd    = 4'b1111;
    #1;
    check("reset_no_edge", '0);
    @(posedge clk);
    #1;
    check("reset_held_edge", '0);

    // Release mid-cycle; first decode appears on the next rising edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("release_before_edge", '0);
    @(posedge clk);
    #1;
    check("first_decode", ref_model(2'b00, 6'b101001, 4'b1111));

    // Async assert mid-cycle clears outputs without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", '0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    vecs.push_back('{"dp_and_reg",  2'b00, 6'b000000, 4'b0000,
                     pk(2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10)});
    vecs.push_back('{"str_rd0",     2'b01, 6'b000000, 4'b0000,
                     pk(2'b00, 0, 0, 1, 1, 1, 2'b01, 2'b10, 2'b00)});
    vecs.push_back('{"str_rd2",     2'b01, 6'b000000, 4'b0010,
                     pk(2'b00, 0, 0, 1, 1, 1, 2'b01, 2'b10, 2'b00)});
    vecs.push_back('{"str_f04",     2'b01, 6'b000100, 4'b0010,
                     pk(2'b00, 0, 0, 1, 1, 1, 2'b01, 2'b10, 2'b00)});
    vecs.push_back('{"str_to_pc",   2'b01, 6'b000000, 4'b1111,
                     pk(2'b00, 0, 0, 1, 1, 1, 2'b01, 2'b10, 2'b00)});
    vecs.push_back('{"ldr_to_pc",   2'b01, 6'b000001, 4'b1111,
                     pk(2'b00, 1, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00)});
    vecs.push_back('{"adds_imm",    2'b00, 6'b101001, 4'b0000,
                     pk(2'b11, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00)});
    vecs.push_back('{"orrs_reg",    2'b00, 6'b011001, 4'b0000,
                     pk(2'b10, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11)});
    vecs.push_back('{"branch",      2'b10, 6'b000000, 4'b0000,
                     pk(2'b00, 1, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00)});
    vecs.push_back('{"undef_op",    2'b11, 6'b111111, 4'b1111, 13'b0});
    vecs.push_back('{"illegal_cmd", 2'b00, 6'b001110, 4'b0000, 13'b0});
    vecs.push_back('{"illegal_pc",  2'b00, 6'b100111, 4'b1111,
                     pk(2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00)});
    vecs.push_back('{"subs_to_pc",  2'b00, 6'b000101, 4'b1111,
                     pk(2'b11, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01)});
    vecs.push_back('{"ands_reg",    2'b00, 6'b000001, 4'b0011,
                     pk(2'b10, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10)});
    vecs.push_back('{"add_imm_ns",  2'b00, 6'b101000, 4'b0001,
                     pk(2'b00, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00)});
    foreach (vecs[i]) apply(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].exp);

    // Latency: new inputs must not reach the outputs before the next edge.
    apply("lat_setup", 2'b10, 6'b000000, 4'b0000, ref_model(2'b10, 6'b000000, 4'b0000));
    drive(2'b11, 6'b000000, 4'b0000);
    #1;
    check("lat_hold", ref_model(2'b10, 6'b000000, 4'b0000));
    @(posedge clk);
    #1;
    check("lat_update", '0);

    // Randomized back-to-back stream through an expected queue.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      exp_q.push_back(ref_model(op, fn, rd));
      drive(op, fn, rd);
      @(posedge clk);
      #1;
      check("random", exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
